piso_serializer: RTL and testbench

//  Parallel-in/serial-out stage feeding the serial shift-register chain (siso).

---
 rtl/piso_serializer.sv | 123 ++++++++++++
 tb/tb_piso_serializer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: valid/ready word input, one bit per clk out with frame-start strobe.
// Optional macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PISO_PARITY_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  logic             accept;
  logic             last_cycle;
  logic             load_bit;
  logic             adv_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] adv_rest;

  // Bit selection: first bit of a new word, and next bit of the word in flight
  always_comb begin
    load_bit  = in_data[0];
    load_rest = {1'b0, in_data[WIDTH-1:1]};
    adv_bit   = sreg[0];
    adv_rest  = {1'b0, sreg[WIDTH-1:1]};
    if (!LSB_FIRST) begin
      load_bit  = in_data[WIDTH-1];
      load_rest = {in_data[WIDTH-2:0], 1'b0};
      adv_bit   = sreg[WIDTH-1];
      adv_rest  = {sreg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef PISO_PARITY_EN
  assign last_cycle = (state == PAR);
`else
  assign last_cycle = (state == SHIFT) && (cnt == LAST);
`endif

  assign in_ready = !rst && ((state == IDLE) || last_cycle);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      busy      <= 1'b0;
`ifdef PISO_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (accept) begin
      // A load in the last frame cycle chains the next frame with no gap
      state     <= SHIFT;
      sreg      <= load_rest;
      cnt       <= '0;
      ser_out   <= load_bit;
      ser_valid <= 1'b1;
      ser_first <= 1'b1;
      busy      <= 1'b1;
`ifdef PISO_PARITY_EN
      par       <= ^in_data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != LAST) begin
            cnt       <= cnt + CW'(1);
            sreg      <= adv_rest;
            ser_out   <= adv_bit;
            ser_first <= 1'b0;
          end else begin
`ifdef PISO_PARITY_EN
            state     <= PAR;
            ser_out   <= par;
            ser_first <= 1'b0;
`else
            state     <= IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            busy      <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          ser_first <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first and MSB-first instances share one stimulus.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ready_l, ser_l, sv_l, sf_l, busy_l;
  logic       ready_m, ser_m, sv_m, sf_m, busy_m;

  int n_checks = 0;
  int n_errors = 0;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_l), .in_data(in_data),
    .ser_out(ser_l), .ser_valid(sv_l), .ser_first(sf_l), .busy(busy_l)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_m), .in_data(in_data),
    .ser_out(ser_m), .ser_valid(sv_m), .ser_first(sf_m), .busy(busy_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " sv_l"}, 32'(sv_l), 32'd0);
    check({tag, " ser_l"}, 32'(ser_l), 32'd0);
    check({tag, " busy_l"}, 32'(busy_l), 32'd0);
    check({tag, " rdy_l"}, 32'(ready_l), 32'd1);
    check({tag, " sv_m"}, 32'(sv_m), 32'd0);
    check({tag, " ser_m"}, 32'(ser_m), 32'd0);
    check({tag, " busy_m"}, 32'(busy_m), 32'd0);
    check({tag, " rdy_m"}, 32'(ready_m), 32'd1);
  endtask

  // Present a word from idle and confirm the stage offers to take it
  task automatic start_word(input logic [7:0] w);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    check("start rdy_l", 32'(ready_l), 32'd1);
    check("start rdy_m", 32'(ready_m), 32'd1);
  endtask

  // Called in the accept cycle (after its negedge); checks the whole frame
  task automatic run_frame(input logic [7:0] w, input logic nv, input logic [7:0] nw);
    logic exp_rdy;
    @(posedge clk); #1;
    in_valid = nv;
    in_data  = nw;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef PISO_PARITY_EN
      exp_rdy = 1'b0;
`else
      exp_rdy = (i == 7);
`endif
      check("frm sv_l", 32'(sv_l), 32'd1);
      check("frm sv_m", 32'(sv_m), 32'd1);
      check("frm sf_l", 32'(sf_l), 32'(i == 0));
      check("frm sf_m", 32'(sf_m), 32'(i == 0));
      check("frm ser_l", 32'(ser_l), 32'(w[i]));
      check("frm ser_m", 32'(ser_m), 32'(w[7-i]));
      check("frm busy_l", 32'(busy_l), 32'd1);
      check("frm rdy_l", 32'(ready_l), 32'(exp_rdy));
      check("frm rdy_m", 32'(ready_m), 32'(exp_rdy));
    end
`ifdef PISO_PARITY_EN
    @(negedge clk);
    check("par sv_l", 32'(sv_l), 32'd1);
    check("par sf_l", 32'(sf_l), 32'd0);
    check("par ser_l", 32'(ser_l), 32'(^w));
    check("par ser_m", 32'(ser_m), 32'(^w));
    check("par rdy_l", 32'(ready_l), 32'd1);
    check("par rdy_m", 32'(ready_m), 32'd1);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3;
    check("rst sv", 32'(sv_l), 32'd0);
    check("rst ser", 32'(ser_l), 32'd0);
    check("rst sf", 32'(sf_l), 32'd0);
    check("rst busy", 32'(busy_l), 32'd0);
    check("rst rdy_l", 32'(ready_l), 32'd0);
    check("rst rdy_m", 32'(ready_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post-rst");

    // Single frames: A5 is a palindrome in bit order, 80 and 07 are not
    start_word(8'hA5);
    run_frame(8'hA5, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after A5");

    start_word(8'h80);
    run_frame(8'h80, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after 80");

    start_word(8'h07);
    run_frame(8'h07, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after 07");

    // Back-to-back frames with in_valid held high
    start_word(8'hA5);
    run_frame(8'hA5, 1'b1, 8'h3C);
    run_frame(8'h3C, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after b2b");

    // Reset in the middle of an all-ones frame
    start_word(8'hFF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid-rst sv_l", 32'(sv_l), 32'd0);
    check("mid-rst ser_l", 32'(ser_l), 32'd0);
    check("mid-rst busy_l", 32'(busy_l), 32'd0);
    check("mid-rst sv_m", 32'(sv_m), 32'd0);
    check("mid-rst rdy_l", 32'(ready_l), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("rst release");
    start_word(8'h01);
    run_frame(8'h01, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after 01");

    // in_data toggling without in_valid must not start anything
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_data = i[0] ? 8'h55 : 8'hAA;
      @(negedge clk);
      check_idle("idle");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
